mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage pipeline, directly downstream of the EX/MEM interstage register. Consumes the registered WB/M control, ALU result, store data and destination register. Performs loads and stores over a req/ack data-memory bus, stalling the front of the pipeline while an access is outstanding. Registers the results into the MEM/WB fields consumed by write-back.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles in WAIT without `dmem_ack` before the access is aborted (≥2)

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately
- WBIn  in  2  WB control from EX/MEM, passed through to MEM/WB
- MIn  in  3  M control: bit0 memRead, bit1 memWrite, bit2 branch (ignored here)
- ALUIn  in  32  ALU result; byte address when accessing memory
- writeDataIn  in  32  store data
- rdIn  in  5  destination register
- dmem_req  out  1  request valid, held until ack
- dmem_we  out  1  1 = store, 0 = load; valid with req
- dmem_addr  out  32  word-aligned address, held with req
- dmem_wdata  out  32  store data, held with req
- dmem_rdata  in  32  load data, valid when ack
- dmem_ack  in  1  one-cycle completion strobe
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
- mem_error  out  1  one-cycle registered pulse: misaligned or timed out
- WBOut  out  2  MEM/WB write-back control
- readDataOut  out  32  MEM/WB load data
- ALUOut  out  32  MEM/WB ALU result
- rdOut  out  5  MEM/WB destination register

## Operation
- access = MIn[0] | MIn[1]. If both bits are set, the access is a store.
- States: IDLE, WAIT.
- IDLE, no access: MEM/WB captures WBIn, ALUIn, rdIn, and readDataOut=0 every edge.
- IDLE, access, ALUIn[1:0]≠0 (misaligned): no request, no stall. MEM/WB loads a bubble (WBOut=0, others 0). mem_error pulses.
- IDLE, aligned access: stall=1. At the edge: dmem_req←1, dmem_we←MIn[1], dmem_addr←ALUIn, dmem_wdata←writeDataIn, timeout counter←0, state←WAIT, MEM/WB←bubble.
- WAIT, dmem_ack=0: stall=1 and counter increments.
  - At counter = TIMEOUT−1: dmem_req←0, MEM/WB←bubble, mem_error pulses, state←IDLE, and stall drops in that cycle.
- WAIT, dmem_ack=1: stall=0. At the edge:
  - dmem_req←0, state←IDLE.
  - MEM/WB←{WBIn, ALUIn, rdIn}.
  - readDataOut←dmem_rdata for loads, 0 for stores.
- stall = (IDLE & access & aligned) | (WAIT & !dmem_ack & !timeout_hit).
- Because EX/MEM is frozen by stall, WBIn/ALUIn/rdIn are stable across the whole access.
- A dmem_ack in IDLE is ignored.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, mem_error=0, WBOut=0, readDataOut=0, ALUOut=0, rdOut=0, counter=0. stall reads 0 while reset is low.
- Reset asserted mid-WAIT: the request is dropped immediately. A late ack after reset release is ignored.
- Non-memory instruction: 1-cycle latency, EX/MEM→MEM/WB.
- Memory access with ack arriving k cycles after req rises (k≥1): stall high for k+1 cycles. Result in MEM/WB on the edge where ack is sampled.
- Minimum access is 2 cycles: request edge, then ack edge.
- Back-to-back accesses: req drops for at least one cycle between them, because the IDLE request cycle re-arms it.
- mem_error is high for exactly one cycle per fault.
- Counter width is $clog2(TIMEOUT). The counter never wraps: the timeout fires first.

## Structure
- Shared package `mem_pkg`:
  - state encoding (IDLE, WAIT)
  - M bit indices (MEM_READ=0, MEM_WRITE=1, BRANCH=2)
  - bubble constants
- Sub-module `mem_wb`: MEM/WB interstage register with async active-low reset and a load/bubble select. The FSM, counter and bus driving stay in mem_stage.

## Test plan
- Reset while req=1 in WAIT → dmem_req, WBOut and rdOut read 0 at once; a following ack produces no MEM/WB update.
- ALU op (MIn=0, WBIn=2'b10, ALUIn=32'h0000_00AA, rdIn=5) → next edge: WBOut=2'b10, ALUOut=32'hAA, rdOut=5; stall never asserted.
- Load at 32'h0000_0010, ack 3 cycles after req with rdata 32'hDEAD_BEEF → stall high 4 cycles; readDataOut=32'hDEADBEEF, WBOut=WBIn; req held with stable addr until ack.
- Store (MIn=3'b010) at 32'h20, data 32'h1234_5678 → dmem_we=1, dmem_wdata=32'h12345678; readDataOut=0 after ack.
- Misaligned load at 32'h0000_0013 → no req, stall=0, mem_error one-cycle pulse, MEM/WB bubble.
- No ack with TIMEOUT=4 → req high 4 cycles then drops, mem_error pulses once, bubble in MEM/WB, pipeline resumes.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM states, M-control bit
// positions and the MEM/WB bubble value.
package mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Bit positions inside the 3-bit M control field
    localparam int MEM_READ  = 0;
    localparam int MEM_WRITE = 1;
    localparam int BRANCH    = 2;

    // One MEM/WB entry as seen by write-back
    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } memwb_t;

    localparam logic [31:0] WORD_ZERO    = 32'h0000_0000;
    localparam memwb_t      MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB interstage register. Holds its value unless load is set; on load it
// takes either the incoming entry or a bubble.
module mem_wb
    import mem_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);

    memwb_t r_q;
    memwb_t r_d;

    // Select hold, bubble or new entry
    always_comb begin
        r_d = r_q;
        if (load) begin
            r_d = bubble ? MEMWB_BUBBLE : d;
        end
    end

    // Interstage register, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= MEMWB_BUBBLE;
        end else begin
            r_q <= r_d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on the req/ack data bus, stalls the
// front of the pipeline while an access is outstanding, aborts on timeout
// and writes results into the MEM/WB register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  WBIn,
    input  logic [2:0]  MIn,
    input  logic [31:0] ALUIn,
    input  logic [31:0] writeDataIn,
    input  logic [4:0]  rdIn,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        mem_error,
    output logic [1:0]  WBOut,
    output logic [31:0] readDataOut,
    output logic [31:0] ALUOut,
    output logic [4:0]  rdOut
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;

    logic               access;
    logic               aligned;
    logic               timeout_hit;
    logic               wb_load;
    logic               wb_bubble;
    logic [31:0]        wb_rdata;
    memwb_t             wb_entry;
    memwb_t             wb_out;
    logic               branch_unused;

    // The branch bit is resolved elsewhere; it is carried but not used here
    assign branch_unused = MIn[BRANCH];

    assign access      = MIn[MEM_READ] | MIn[MEM_WRITE];
    assign aligned     = (ALUIn[1:0] == 2'b00);
    assign timeout_hit = (state_q == ST_WAIT) && !dmem_ack
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Stall is held low during reset so the front end is never frozen by it
    assign stall = reset &&
                   (((state_q == ST_IDLE) && access && aligned) ||
                    ((state_q == ST_WAIT) && !dmem_ack && !timeout_hit));

    // Next-state, bus and MEM/WB control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_rdata  = WORD_ZERO;
        case (state_q)
            ST_IDLE: begin
                wb_load = 1'b1;
                if (access) begin
                    wb_bubble = 1'b1;
                    if (!aligned) begin
                        err_d = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = MIn[MEM_WRITE];
                        addr_d  = ALUIn;
                        wdata_d = writeDataIn;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    req_d    = 1'b0;
                    state_d  = ST_IDLE;
                    wb_load  = 1'b1;
                    wb_rdata = we_q ? WORD_ZERO : dmem_rdata;
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    state_d   = ST_IDLE;
                    wb_load   = 1'b1;
                    wb_bubble = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counter and bus registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= WORD_ZERO;
            wdata_q <= WORD_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign wb_entry = '{wb: WBIn, alu: ALUIn, rdata: wb_rdata, rd: rdIn};

    mem_wb u_mem_wb (
        .clock  (clock),
        .reset  (reset),
        .load   (wb_load),
        .bubble (wb_bubble),
        .d      (wb_entry),
        .q      (wb_out)
    );

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign mem_error   = err_q;
    assign WBOut       = wb_out.wb;
    assign ALUOut      = wb_out.alu;
    assign readDataOut = wb_out.rdata;
    assign rdOut       = wb_out.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (TIMEOUT=4): stimulus pushes the expected
// MEM/WB entry per instruction, a monitor pops whenever the pipeline advances.
module tb_mem_stage;

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [1:0]  WBIn;
    logic [2:0]  MIn;
    logic [31:0] ALUIn;
    logic [31:0] writeDataIn;
    logic [4:0]  rdIn;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        mem_error;
    logic [1:0]  WBOut;
    logic [31:0] readDataOut;
    logic [31:0] ALUOut;
    logic [4:0]  rdOut;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    logic        ex_valid   = 1'b0;
    logic        resp_en    = 1'b1;
    logic        ack_never  = 1'b0;
    int          ack_wait   = 0;
    logic [31:0] rdata_cfg  = 32'h0;

    int          stall_cycles;
    int          req_cycles;
    logic        bus_stable;
    logic        first_req;
    logic        seen_we;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;

    mem_stage #(.TIMEOUT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .WBIn        (WBIn),
        .MIn         (MIn),
        .ALUIn       (ALUIn),
        .writeDataIn (writeDataIn),
        .rdIn        (rdIn),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .stall       (stall),
        .mem_error   (mem_error),
        .WBOut       (WBOut),
        .readDataOut (readDataOut),
        .ALUOut      (ALUOut),
        .rdOut       (rdOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] wb, input logic [31:0] alu,
                                input logic [4:0] rd, input logic [31:0] rdata,
                                input logic err);
        exp_t e;
        e.wb = wb; e.alu = alu; e.rd = rd; e.rdata = rdata; e.err = err;
        return e;
    endfunction

    // Data-memory responder: acks after ack_wait idle WAIT cycles
    initial begin
        int wcnt;
        wcnt = 0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            if (resp_en) begin
                if (!reset) begin
                    dmem_ack = 1'b0;
                    wcnt = 0;
                end else if (dmem_req && !dmem_ack) begin
                    if (!ack_never && wcnt == ack_wait) begin
                        dmem_ack = 1'b1;
                        dmem_rdata = rdata_cfg;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    dmem_ack = 1'b0;
                    dmem_rdata = 32'h0;
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: one MEM/WB entry is produced on every edge the pipeline advances
    initial begin
        logic s, v, r;
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            s = stall; v = ex_valid; r = reset;
            @(posedge clock);
            #1;
            if (v && !s && r && reset) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_WBOut",       {30'd0, WBOut}, {30'd0, e.wb});
                    check("sb_ALUOut",      ALUOut, e.alu);
                    check("sb_rdOut",       {27'd0, rdOut}, {27'd0, e.rd});
                    check("sb_readDataOut", readDataOut, e.rdata);
                    check("sb_mem_error",   {31'd0, mem_error}, {31'd0, e.err});
                end
            end
        end
    end

    // Present one instruction in EX/MEM until the stage accepts it
    task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd, input exp_t e);
        logic s;
        int   n;
        exp_q.push_back(e);
        WBIn = wb; MIn = m; ALUIn = alu; writeDataIn = wd; rdIn = rd; ex_valid = 1'b1;
        stall_cycles = 0; req_cycles = 0; bus_stable = 1'b1; first_req = 1'b0;
        seen_we = 1'b0; seen_addr = 32'h0; seen_wdata = 32'h0;
        for (n = 0; n < 64; n++) begin
            #1;
            s = stall;
            if (n == 0) first_req = dmem_req;
            if (dmem_req) begin
                if (req_cycles == 0) begin
                    seen_we = dmem_we; seen_addr = dmem_addr; seen_wdata = dmem_wdata;
                end else if (dmem_we !== seen_we || dmem_addr !== seen_addr ||
                             dmem_wdata !== seen_wdata) begin
                    bus_stable = 1'b0;
                end
                req_cycles++;
            end
            if (s) stall_cycles++;
            @(negedge clock);
            if (!s) break;
        end
        if (n >= 64) check("issue_cycle_budget", 32'd1, 32'd0);
        ex_valid = 1'b0;
        WBIn = 2'b00; MIn = 3'b000; ALUIn = 32'h0; writeDataIn = 32'h0; rdIn = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired actual=%0d required=0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        WBIn = 2'b11; MIn = 3'b001; ALUIn = 32'h10; writeDataIn = 32'h55; rdIn = 5'd3;
        #2 reset = 1'b0;
        #1;
        // Reset state, with an aligned load presented so stall gating is exercised
        check("rst_dmem_req",   {31'd0, dmem_req}, 32'd0);
        check("rst_dmem_we",    {31'd0, dmem_we}, 32'd0);
        check("rst_dmem_addr",  dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_stall",      {31'd0, stall}, 32'd0);
        check("rst_mem_error",  {31'd0, mem_error}, 32'd0);
        check("rst_WBOut",      {30'd0, WBOut}, 32'd0);
        check("rst_readData",   readDataOut, 32'd0);
        check("rst_ALUOut",     ALUOut, 32'd0);
        check("rst_rdOut",      {27'd0, rdOut}, 32'd0);
        WBIn = 2'b00; MIn = 3'b000; ALUIn = 32'h0; writeDataIn = 32'h0; rdIn = 5'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Plain ALU op passes straight through
        issue(2'b10, 3'b000, 32'h0000_00AA, 32'h0, 5'd5, mk(2'b10, 32'hAA, 5'd5, 32'h0, 1'b0));
        check("alu_stall_cycles", stall_cycles, 0);
        check("alu_req_cycles",   req_cycles, 0);

        // Load with three idle WAIT cycles before ack
        ack_wait = 3; rdata_cfg = 32'hDEAD_BEEF;
        issue(2'b11, 3'b001, 32'h0000_0010, 32'h0, 5'd7, mk(2'b11, 32'h10, 5'd7, 32'hDEAD_BEEF, 1'b0));
        check("ld_stall_cycles", stall_cycles, 4);
        check("ld_req_cycles",   req_cycles, 4);
        check("ld_bus_stable",   {31'd0, bus_stable}, 32'd1);
        check("ld_addr",         seen_addr, 32'h10);
        check("ld_we",           {31'd0, seen_we}, 32'd0);

        // Store: read data must be zeroed even though the bus returns data
        ack_wait = 0; rdata_cfg = 32'hFFFF_FFFF;
        issue(2'b01, 3'b010, 32'h0000_0020, 32'h1234_5678, 5'd9, mk(2'b01, 32'h20, 5'd9, 32'h0, 1'b0));
        check("st_stall_cycles", stall_cycles, 1);
        check("st_we",           {31'd0, seen_we}, 32'd1);
        check("st_wdata",        seen_wdata, 32'h1234_5678);
        check("st_addr",         seen_addr, 32'h20);

        // Both read and write set: treated as a store
        ack_wait = 1; rdata_cfg = 32'hAAAA_5555;
        issue(2'b10, 3'b011, 32'h0000_0024, 32'hCAFE_F00D, 5'd10, mk(2'b10, 32'h24, 5'd10, 32'h0, 1'b0));
        check("rw_stall_cycles", stall_cycles, 2);
        check("rw_we",           {31'd0, seen_we}, 32'd1);
        check("rw_wdata",        seen_wdata, 32'hCAFE_F00D);

        // Misaligned load: bubble, error pulse, no request
        issue(2'b11, 3'b001, 32'h0000_0013, 32'h0, 5'd11, mk(2'b00, 32'h0, 5'd0, 32'h0, 1'b1));
        check("mis_stall_cycles", stall_cycles, 0);
        check("mis_req_cycles",   req_cycles, 0);
        @(negedge clock);
        check("mis_error_one_cycle", {31'd0, mem_error}, 32'd0);

        // No ack: request dropped after TIMEOUT cycles
        ack_never = 1'b1;
        issue(2'b11, 3'b001, 32'h0000_0030, 32'h0, 5'd12, mk(2'b00, 32'h0, 5'd0, 32'h0, 1'b1));
        check("to_stall_cycles", stall_cycles, 4);
        check("to_req_cycles",   req_cycles, 4);
        check("to_req_dropped",  {31'd0, dmem_req}, 32'd0);
        @(negedge clock);
        check("to_error_one_cycle", {31'd0, mem_error}, 32'd0);
        ack_never = 1'b0;

        // Back-to-back loads: the second starts with req low
        ack_wait = 0; rdata_cfg = 32'h1111_1111;
        issue(2'b01, 3'b001, 32'h0000_0050, 32'h0, 5'd13, mk(2'b01, 32'h50, 5'd13, 32'h1111_1111, 1'b0));
        rdata_cfg = 32'h2222_2222;
        issue(2'b11, 3'b001, 32'h0000_0054, 32'h0, 5'd14, mk(2'b11, 32'h54, 5'd14, 32'h2222_2222, 1'b0));
        check("b2b_first_req_low", {31'd0, first_req}, 32'd0);
        check("b2b_addr",          seen_addr, 32'h54);

        // Reset in the middle of an outstanding access
        ack_never = 1'b1;
        WBIn = 2'b11; MIn = 3'b001; ALUIn = 32'h0000_0040; rdIn = 5'd4;
        @(negedge clock);
        @(negedge clock);
        check("mid_req_before_reset", {31'd0, dmem_req}, 32'd1);
        #3 reset = 1'b0;
        #1;
        check("mid_req_cleared",   {31'd0, dmem_req}, 32'd0);
        check("mid_WBOut_cleared", {30'd0, WBOut}, 32'd0);
        check("mid_rdOut_cleared", {27'd0, rdOut}, 32'd0);
        check("mid_stall_low",     {31'd0, stall}, 32'd0);
        WBIn = 2'b00; MIn = 3'b000; ALUIn = 32'h0; rdIn = 5'd0;
        @(negedge clock);
        reset = 1'b1;
        ack_never = 1'b0;
        // Late ack arrives while idle and must not reach MEM/WB
        resp_en = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        resp_en = 1'b1;
        #1;
        check("late_ack_readData", readDataOut, 32'd0);
        check("late_ack_req",      {31'd0, dmem_req}, 32'd0);
        check("late_ack_error",    {31'd0, mem_error}, 32'd0);
        @(negedge clock);

        // Pipeline recovers after reset
        issue(2'b01, 3'b000, 32'h0000_0077, 32'h0, 5'd31, mk(2'b01, 32'h77, 5'd31, 32'h0, 1'b0));
        check("post_rst_stall_cycles", stall_cycles, 0);

        @(negedge clock);
        @(negedge clock);
        check("sb_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
